// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The bit counter must be able to hold the value w itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial datapath.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: LSB-first through one full-adder cell and a carry flop,
// with valid/ready handshakes on both the operand and result sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one sum bit produced per clock, WIDTH clocks
// DONE  | result presented, held until out_ready
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  fa_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            carry_q  <= cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so the word is aligned after WIDTH shifts.
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          carry_q <= fa_co;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed cases on WIDTH=8, random streams on WIDTH=8 and 13.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [7:0] a8, b8, sum8;

  logic        in_valid13, in_ready13, cin13, out_valid13, out_ready13, cout13, busy13;
  logic [12:0] a13, b13, sum13;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8)
  );

  serial_adder #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid13), .in_ready(in_ready13),
    .a(a13), .b(b13), .cin(cin13), .out_valid(out_valid13), .out_ready(out_ready13),
    .sum(sum13), .cout(cout13), .busy(busy13)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [8:0]  q8[$];
  logic [13:0] q13[$];
  int n_acc8 = 0, n_res8 = 0, n_acc13 = 0, n_res13 = 0;
  bit done8 = 1'b0, done13 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Result monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      logic [8:0] e;
      n_res8++;
      check("q8_pending", 64'(q8.size() > 0), 64'd1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check("result8", 64'({cout8, sum8}), 64'(e));
      end
    end
    if (rst_n && out_valid13 && out_ready13) begin
      logic [13:0] e;
      n_res13++;
      check("q13_pending", 64'(q13.size() > 0), 64'd1);
      if (q13.size() > 0) begin
        e = q13.pop_front();
        check("result13", 64'({cout13, sum13}), 64'(e));
      end
    end
  end

  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input bit push, input logic [8:0] e);
    int g = 0;
    a8 = av; b8 = bv; cin8 = cv; in_valid8 = 1'b1;
    while (!in_ready8 && g < 300) begin @(posedge clk); #1; g++; end
    if (g >= 300) check("accept8_timeout", 64'(in_ready8), 64'd1);
    if (push) begin q8.push_back(e); n_acc8++; end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic send13(input logic [12:0] av, input logic [12:0] bv, input logic cv,
                        input logic [13:0] e);
    int g = 0;
    a13 = av; b13 = bv; cin13 = cv; in_valid13 = 1'b1;
    while (!in_ready13 && g < 300) begin @(posedge clk); #1; g++; end
    if (g >= 300) check("accept13_timeout", 64'(in_ready13), 64'd1);
    q13.push_back(e); n_acc13++;
    @(posedge clk); #1;
    in_valid13 = 1'b0;
  endtask

  task automatic wait_ov8(output int k);
    k = 0;
    while (!out_valid8 && k < 100) begin @(posedge clk); #1; k++; end
  endtask

  task automatic wait_idle8();
    int g = 0;
    while (!(in_ready8 && q8.size() == 0) && g < 300) begin @(posedge clk); #1; g++; end
    if (g >= 300) check("idle8_timeout", 64'(in_ready8), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit spurious;
    in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; out_ready8 = 0;
    in_valid13 = 0; a13 = 0; b13 = 0; cin13 = 0; out_ready13 = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_in_ready", 64'(in_ready8), 64'd1);
    check("rst_out_valid", 64'(out_valid8), 64'd0);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_sum", 64'(sum8), 64'd0);
    check("rst_cout", 64'(cout8), 64'd0);
    check("rst_in_ready13", 64'(in_ready13), 64'd1);

    // Basic add and latency
    out_ready8 = 1'b1;
    send8(8'd3, 8'd5, 1'b0, 1'b1, 9'h008);
    check("run_busy", 64'(busy8), 64'd1);
    check("run_in_ready", 64'(in_ready8), 64'd0);
    wait_ov8(lat);
    check("latency", 64'(lat), 64'd8);
    check("basic_sum", 64'(sum8), 64'd8);
    check("no_overlap", 64'(in_ready8), 64'd0);
    @(posedge clk); #1;
    check("after_in_ready", 64'(in_ready8), 64'd1);
    check("after_out_valid", 64'(out_valid8), 64'd0);
    check("after_busy", 64'(busy8), 64'd0);

    // Wrap and all-ones corner
    send8(8'hFF, 8'h01, 1'b0, 1'b1, 9'h100);
    send8(8'hFF, 8'hFF, 1'b1, 1'b1, 9'h1FF);
    wait_idle8();

    // Backpressure with operand churn
    out_ready8 = 1'b0;
    send8(8'h12, 8'h34, 1'b1, 1'b1, 9'h047);
    wait_ov8(lat);
    check("bp_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 6; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = ~cin8; in_valid8 = i[0];
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid8), 64'd1);
      check("bp_sum", 64'(sum8), 64'h47);
      check("bp_cout", 64'(cout8), 64'd0);
      check("bp_in_ready", 64'(in_ready8), 64'd0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ov", 64'(out_valid8), 64'd0);
    check("bp_release_ir", 64'(in_ready8), 64'd1);

    // Reset in the middle of RUN
    send8(8'hAA, 8'h55, 1'b0, 1'b0, 9'h000);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready8), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid8), 64'd0);
    check("mid_rst_sum", 64'(sum8), 64'd0);
    check("mid_rst_busy", 64'(busy8), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid8) spurious = 1'b1;
    end
    check("no_spurious_ov", 64'(spurious), 64'd0);
    send8(8'd1, 8'd1, 1'b0, 1'b1, 9'h002);
    wait_idle8();

    // Random streams on both widths
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [7:0] av, bv;
          logic cv;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
          send8(av, bv, cv, 1'b1, {1'b0, av} + {1'b0, bv} + 9'(cv));
        end
        done8 = 1'b1;
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [12:0] av, bv;
          logic cv;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          av = 13'($urandom); bv = 13'($urandom); cv = 1'($urandom);
          send13(av, bv, cv, {1'b0, av} + {1'b0, bv} + 14'(cv));
        end
        done13 = 1'b1;
      end
      begin
        while (!done8) begin @(posedge clk); #1; out_ready8 = ($urandom_range(0, 3) != 0); end
        out_ready8 = 1'b1;
      end
      begin
        while (!done13) begin @(posedge clk); #1; out_ready13 = ($urandom_range(0, 3) != 0); end
        out_ready13 = 1'b1;
      end
    join

    for (int g = 0; g < 300 && (q8.size() != 0 || q13.size() != 0); g++) begin
      @(posedge clk); #1;
    end
    check("drain8", 64'(q8.size()), 64'd0);
    check("drain13", 64'(q13.size()), 64'd0);
    check("count8", 64'(n_res8), 64'(n_acc8));
    check("count13", 64'(n_res13), 64'(n_acc13));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
